// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB completer memory.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Wait-state counter width; covers WAIT_CYCLES 0..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W flop array: one write port, one registered read port,
// everything cleared by a synchronous reset.
module apb_slave_regfile #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next memory image and read register; rzero forces a zero read for
    // addresses the caller has decoded as out of range.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        if (re) begin
            rdata_d = rzero ? '0 : mem_q[raddr];
        end
    end

    // Storage and read register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register memory, with programmable wait states
// and an error response for addresses at or above DEPTH.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE, where address/direction/data are latched. It completes on the first
// rising edge where psel & penable & pready are all 1; pready and pslverr come
// only from registered state, never combinationally from the bus inputs.
// Dropping psel before completion abandons the transfer without a write.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output apb_state_e        dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic in_range;
    logic rd_en;
    logic wr_en;

    // Range decode of the live address, only consumed in the setup cycle.
    always_comb begin
        in_range = (32'(paddr) < DEPTH);
    end

    // Next-state, latch capture, wait countdown and write/read strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr[IDX_W-1:0];
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    err_d   = !in_range;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    rd_en   = 1'b1;
                    state_d = (WAIT_CYCLES == 0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    wr_en   = wr_q && !err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched transfer attributes.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    apb_slave_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk   (pclk),
        .rst   (preset),
        .we    (wr_en),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (rd_en),
        .rzero (!in_range),
        .raddr (paddr[IDX_W-1:0]),
        .rdata (prdata)
    );

    assign pready    = (state_q == READY);
    assign pslverr   = (state_q == READY) && err_q;
    assign dbg_state = state_q;

endmodule
